axi_rr_arbiter: RTL and testbench
=================================

// Module: axi_rr_arbiter
// PURPOSE
// - Per-slave AXI address arbiter for the interconnect; successor to the first-come read/write lock scheme.
// - Each slave port s (0..NUM_S; s=0 is the default/decode-error slave) has independent read and write
//   channels, each granted round-robin to one master and held until that burst's response completes.
// - Drives routing indices to the R/W muxes: slave->master (SRIdx/SWIdx) and master->slave (MRIdx/MWIdx).
// PARAMETERS
// - NUM_M      3   number of masters
// - NUM_S      6   number of real slaves; ports indexed 0..NUM_S
// - MIDX_BITS  2   width of master index (must hold NUM_M)
// - SIDX_BITS  3   width of slave index (must hold NUM_S+1)
// - TIMEOUT    256 watchdog limit in cycles (used only with ARB_WDT_EN)
// PORTS
// - clk        in   1                     clock; reset rst, asynchronous, active-low
// - rst        in   1                     asynchronous active-low reset
// - R_REQ      in   [NUM_S:0][NUM_M-1:0]  ARVALID of master m decoded to slave s
// - W_REQ      in   [NUM_S:0][NUM_M-1:0]  AWVALID of master m decoded to slave s
// - ARREADY_S  in   [NUM_S:0]             slave AR ready
// - AWREADY_S  in   [NUM_S:0]             slave AW ready
// - RVALID_S / RLAST_S / BVALID_S  in [NUM_S:0]  slave response signals
// - RREADY_M / BREADY_M            in [NUM_M-1:0] master response ready
// - SRIdx, SWIdx  out  [NUM_S:0][MIDX_BITS-1:0]  owner master+1 per slave; 0 = none
// - MRIdx, MWIdx  out  [NUM_M-1:0][SIDX_BITS-1:0] connected slave+1 per master; 0 = none
// - TO_R, TO_W    out  [NUM_S:0]  one-cycle watchdog release pulse per slave channel
// BEHAVIOUR
// - Per slave per channel (read, write independent): FSM IDLE/BUSY, owner reg, RR pointer ptr (0..NUM_M-1).
// - Reset: all FSMs IDLE, owners 0, ptr 0; all index outputs 0, TO_R/TO_W 0.
// - Eligible master m on slave s read: R_REQ[s][m] & ARREADY_S[s] & m owns no read channel on any slave
//   (BUSY). Write identical with W_REQ/AWREADY_S/write ownership.
// - IDLE: winner = first eligible m scanning ptr, ptr+1, ... modulo NUM_M. Indices driven combinationally
//   the same cycle (zero-latency AR/AW pass-through); at clk edge -> BUSY, owner=winner, ptr=(winner+1)%NUM_M.
// - No eligible master: stay IDLE, indices 0, ptr unchanged.
// - BUSY: indices from owner reg; new requests ignored. Read release: RVALID_S&RREADY_M[owner]&RLAST_S;
//   write release: BVALID_S&BREADY_M[owner]. Release -> IDLE at that edge; indices still valid in
//   release cycle; re-arbitration earliest next cycle (1 idle cycle between bursts on one slave channel).
// - Read and write of the same slave may be BUSY simultaneously with different or the same master.
// - MRIdx[m]=s+1 for the slave whose read channel shows m (IDLE winner or BUSY owner); ownership rule
//   guarantees at most one such s. Same for MWIdx.
// - Wrap: ptr from NUM_M-1 wraps to 0. Indices use widths given; s+1/m+1 truncated to SIDX/MIDX_BITS.
// - Reset mid-burst: immediate IDLE, indices 0; in-flight responses are dropped by the mux.
// CONFIGURATION
// - ARB_WDT_EN defined: per slave channel counter cleared on entering BUSY, +1 each BUSY cycle; when it
//   reaches TIMEOUT-1 without release, force IDLE at that edge and pulse TO_R[s]/TO_W[s] high 1 cycle
//   (next cycle). Normal release in same cycle wins, no pulse.
// - ARB_WDT_EN undefined: no counters; TO_R/TO_W tied 0; BUSY held indefinitely.
// TESTING
// - Reset, no requests -> all indices 0, TO_* 0 for 10 cycles.
// - R_REQ[2][0..2]=1, ARREADY_S[2]=1 every idle cycle, 4-beat bursts -> grants M0,M1,M2,M0; SRIdx[2]=1,2,3,1.
// - M1 reads S1 and writes S3 concurrently -> MRIdx[1]=2, MWIdx[1]=4, both released independently.
// - M0 BUSY on S1 read, also R_REQ[4][0] -> S4 stays IDLE until S1 RLAST handshake, then grants M0.
// - RLAST with RREADY_M[owner]=0 held 5 cycles -> stays BUSY, indices stable; released on RREADY.
// - ARB_WDT_EN, TIMEOUT=8, BVALID never -> S2 write FSM IDLE after 8 BUSY cycles, TO_W[2] single pulse.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// Purpose : per-slave AXI AR/AW arbiter; each slave's read and write channel is granted
//           round-robin to one master and held until that burst's response completes.
// Latency : grant indices are combinational in the arbitration cycle; channel goes BUSY at the edge.
// Backpr. : held grant waits on R last-beat / B handshake; a master owning a channel is not
//           eligible elsewhere on that channel type.
// Ports   : clk/rst (async, active-low); R_REQ/W_REQ per slave per master; ARREADY_S/AWREADY_S,
//           RVALID_S/RLAST_S/BVALID_S per slave; RREADY_M/BREADY_M per master;
//           SRIdx/SWIdx (owner master+1 per slave), MRIdx/MWIdx (slave+1 per master), TO_R/TO_W.
// Config  : define ARB_WDT_EN to enable the per-channel BUSY watchdog (TIMEOUT cycles).

module axi_rr_chan #(
  parameter int NUM_M     = 3,
  parameter int MIDX_BITS = 2,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_M-1:0]     req_i,
  input  logic                 rdy_i,
  input  logic [NUM_M-1:0]     owned_i,
  input  logic                 rsp_vld_i,
  input  logic                 rsp_last_i,
  input  logic [NUM_M-1:0]     mrdy_i,
  output logic                 sel_vld_o,
  output logic [MIDX_BITS-1:0] sel_o,
  output logic                 busy_o,
  output logic [MIDX_BITS-1:0] owner_o,
  output logic                 to_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q;
  logic [MIDX_BITS-1:0] owner_q;
  logic [MIDX_BITS-1:0] ptr_q;

  logic [NUM_M-1:0]     elig;
  logic                 hi_vld, lo_vld, win_vld;
  logic [MIDX_BITS-1:0] hi_idx, lo_idx, win;
  logic                 own_rdy;
  logic                 rel;

  // Round-robin search: first eligible at or above ptr, else first eligible overall
  // (which is then necessarily below ptr, giving the wrap-around order).
  always_comb begin
    elig    = req_i & {NUM_M{rdy_i}} & ~owned_i;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    own_rdy = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      if (!hi_vld && elig[m] && (MIDX_BITS'(m) >= ptr_q)) begin
        hi_vld = 1'b1;
        hi_idx = MIDX_BITS'(m);
      end
      if (!lo_vld && elig[m]) begin
        lo_vld = 1'b1;
        lo_idx = MIDX_BITS'(m);
      end
      if (owner_q == MIDX_BITS'(m)) own_rdy = mrdy_i[m];
    end
    win_vld = (state_q == IDLE) && (hi_vld || lo_vld);
    win     = hi_vld ? hi_idx : lo_idx;
    rel     = (state_q == BUSY) && rsp_vld_i && rsp_last_i && own_rdy;
  end

  assign busy_o    = (state_q == BUSY);
  assign owner_o   = owner_q;
  assign sel_vld_o = busy_o || win_vld;
  assign sel_o     = busy_o ? owner_q : win;

`ifdef ARB_WDT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q <= BUSY;
            owner_q <= win;
            ptr_q   <= (win == MIDX_BITS'(NUM_M - 1)) ? '0 : win + MIDX_BITS'(1);
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          // A genuine release in the expiry cycle takes priority and suppresses the pulse.
          if (rel) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            to_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign to_o = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q <= BUSY;
            owner_q <= win;
            ptr_q   <= (win == MIDX_BITS'(NUM_M - 1)) ? '0 : win + MIDX_BITS'(1);
          end
        end
        BUSY: begin
          if (rel) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign to_o = 1'b0;
`endif

endmodule

module axi_rr_arbiter #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 2,
  parameter int SIDX_BITS = 3,
  parameter int TIMEOUT   = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_S:0][NUM_M-1:0]         R_REQ,
  input  logic [NUM_S:0][NUM_M-1:0]         W_REQ,
  input  logic [NUM_S:0]                    ARREADY_S,
  input  logic [NUM_S:0]                    AWREADY_S,
  input  logic [NUM_S:0]                    RVALID_S,
  input  logic [NUM_S:0]                    RLAST_S,
  input  logic [NUM_S:0]                    BVALID_S,
  input  logic [NUM_M-1:0]                  RREADY_M,
  input  logic [NUM_M-1:0]                  BREADY_M,
  output logic [NUM_S:0][MIDX_BITS-1:0]     SRIdx,
  output logic [NUM_S:0][MIDX_BITS-1:0]     SWIdx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0]   MRIdx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0]   MWIdx,
  output logic [NUM_S:0]                    TO_R,
  output logic [NUM_S:0]                    TO_W
);

  logic [NUM_S:0]                r_sel_vld, w_sel_vld;
  logic [NUM_S:0][MIDX_BITS-1:0] r_sel, w_sel;
  logic [NUM_S:0]                r_busy, w_busy;
  logic [NUM_S:0][MIDX_BITS-1:0] r_own, w_own;
  logic [NUM_M-1:0]              r_owned, w_owned;

  // Ownership comes from registered state only, so eligibility never loops through the grant logic.
  always_comb begin
    r_owned = '0;
    w_owned = '0;
    for (int s = 0; s <= NUM_S; s++) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (r_busy[s] && (r_own[s] == MIDX_BITS'(m))) r_owned[m] = 1'b1;
        if (w_busy[s] && (w_own[s] == MIDX_BITS'(m))) w_owned[m] = 1'b1;
      end
    end
  end

  // Master-side route: the ownership rule leaves at most one slave showing a given master.
  always_comb begin
    MRIdx = '0;
    MWIdx = '0;
    for (int s = 0; s <= NUM_S; s++) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (r_sel_vld[s] && (r_sel[s] == MIDX_BITS'(m))) MRIdx[m] = SIDX_BITS'(s + 1);
        if (w_sel_vld[s] && (w_sel[s] == MIDX_BITS'(m))) MWIdx[m] = SIDX_BITS'(s + 1);
      end
    end
  end

  for (genvar s = 0; s <= NUM_S; s++) begin : g_slv
    axi_rr_chan #(
      .NUM_M     (NUM_M),
      .MIDX_BITS (MIDX_BITS),
      .TIMEOUT   (TIMEOUT)
    ) u_rd (
      .clk       (clk),
      .rst       (rst),
      .req_i     (R_REQ[s]),
      .rdy_i     (ARREADY_S[s]),
      .owned_i   (r_owned),
      .rsp_vld_i (RVALID_S[s]),
      .rsp_last_i(RLAST_S[s]),
      .mrdy_i    (RREADY_M),
      .sel_vld_o (r_sel_vld[s]),
      .sel_o     (r_sel[s]),
      .busy_o    (r_busy[s]),
      .owner_o   (r_own[s]),
      .to_o      (TO_R[s])
    );

    // A write burst ends on its single B beat, so "last" is always true.
    axi_rr_chan #(
      .NUM_M     (NUM_M),
      .MIDX_BITS (MIDX_BITS),
      .TIMEOUT   (TIMEOUT)
    ) u_wr (
      .clk       (clk),
      .rst       (rst),
      .req_i     (W_REQ[s]),
      .rdy_i     (AWREADY_S[s]),
      .owned_i   (w_owned),
      .rsp_vld_i (BVALID_S[s]),
      .rsp_last_i(1'b1),
      .mrdy_i    (BREADY_M),
      .sel_vld_o (w_sel_vld[s]),
      .sel_o     (w_sel[s]),
      .busy_o    (w_busy[s]),
      .owner_o   (w_own[s]),
      .to_o      (TO_W[s])
    );

    assign SRIdx[s] = r_sel_vld[s] ? r_sel[s] + MIDX_BITS'(1) : '0;
    assign SWIdx[s] = w_sel_vld[s] ? w_sel[s] + MIDX_BITS'(1) : '0;
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Purpose : directed self-checking bench for axi_rr_arbiter (3 masters, 6+1 slaves, TIMEOUT=8).
// Latency : inputs driven 1ns after posedge, outputs sampled 2ns after posedge.
// Backpr. : response handshakes are driven explicitly per cycle.

module tb_axi_rr_arbiter;

  localparam int NUM_M = 3;
  localparam int NUM_S = 6;
  localparam int MB    = 2;
  localparam int SB    = 3;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NUM_S:0][NUM_M-1:0]  R_REQ, W_REQ;
  logic [NUM_S:0]             ARREADY_S, AWREADY_S, RVALID_S, RLAST_S, BVALID_S;
  logic [NUM_M-1:0]           RREADY_M, BREADY_M;
  logic [NUM_S:0][MB-1:0]     SRIdx, SWIdx;
  logic [NUM_M-1:0][SB-1:0]   MRIdx, MWIdx;
  logic [NUM_S:0]             TO_R, TO_W;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_rr_arbiter #(
    .NUM_M     (NUM_M),
    .NUM_S     (NUM_S),
    .MIDX_BITS (MB),
    .SIDX_BITS (SB),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .R_REQ     (R_REQ),
    .W_REQ     (W_REQ),
    .ARREADY_S (ARREADY_S),
    .AWREADY_S (AWREADY_S),
    .RVALID_S  (RVALID_S),
    .RLAST_S   (RLAST_S),
    .BVALID_S  (BVALID_S),
    .RREADY_M  (RREADY_M),
    .BREADY_M  (BREADY_M),
    .SRIdx     (SRIdx),
    .SWIdx     (SWIdx),
    .MRIdx     (MRIdx),
    .MWIdx     (MWIdx),
    .TO_R      (TO_R),
    .TO_W      (TO_W)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sr"}, 32'(SRIdx), 0);
    chk({tag, "_sw"}, 32'(SWIdx), 0);
    chk({tag, "_mr"}, 32'(MRIdx), 0);
    chk({tag, "_mw"}, 32'(MWIdx), 0);
    chk({tag, "_tor"}, 32'(TO_R), 0);
    chk({tag, "_tow"}, 32'(TO_W), 0);
  endtask

  int exp_m [4] = '{0, 1, 2, 0};

  initial begin
    R_REQ = '0; W_REQ = '0; ARREADY_S = '0; AWREADY_S = '0;
    RVALID_S = '0; RLAST_S = '0; BVALID_S = '0; RREADY_M = '0; BREADY_M = '0;

    // Reset and quiet idle.
    #12;
    chk_all_zero("in_reset");
    tick;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      settle;
      chk_all_zero("idle");
    end

    // Round-robin on slave 2 read, 4-beat bursts, pointer wraps M2 -> M0.
    R_REQ[2] = 3'b111; ARREADY_S[2] = 1'b1; RREADY_M = 3'b111;
    for (int g = 0; g < 4; g++) begin
      settle;
      chk("rr_grant_sr2", 32'(SRIdx[2]), exp_m[g] + 1);
      chk("rr_grant_mr", 32'(MRIdx[exp_m[g]]), 3);
      tick;
      for (int b = 0; b < 4; b++) begin
        RVALID_S[2] = 1'b1;
        RLAST_S[2]  = (b == 3);
        settle;
        chk("rr_hold_sr2", 32'(SRIdx[2]), exp_m[g] + 1);
        tick;
      end
      RVALID_S[2] = 1'b0; RLAST_S[2] = 1'b0;
    end
    R_REQ[2] = '0;
    settle;
    chk("rr_done_sr2", 32'(SRIdx[2]), 0);
    tick;

    // M1 reads S1 and writes S3 at the same time; released independently.
    R_REQ[1] = 3'b010; ARREADY_S[1] = 1'b1;
    W_REQ[3] = 3'b010; AWREADY_S[3] = 1'b1;
    settle;
    chk("dual_mr1", 32'(MRIdx[1]), 2);
    chk("dual_mw1", 32'(MWIdx[1]), 4);
    chk("dual_sr1", 32'(SRIdx[1]), 2);
    chk("dual_sw3", 32'(SWIdx[3]), 2);
    tick;
    R_REQ[1] = '0; W_REQ[3] = '0;
    settle;
    chk("dual_busy_mr1", 32'(MRIdx[1]), 2);
    chk("dual_busy_mw1", 32'(MWIdx[1]), 4);
    tick;
    BVALID_S[3] = 1'b1; BREADY_M = 3'b010;
    settle;
    chk("dual_brel_mw1", 32'(MWIdx[1]), 4);
    tick;
    BVALID_S[3] = 1'b0;
    settle;
    chk("dual_wfree_mw1", 32'(MWIdx[1]), 0);
    chk("dual_wfree_sw3", 32'(SWIdx[3]), 0);
    chk("dual_rheld_mr1", 32'(MRIdx[1]), 2);
    RVALID_S[1] = 1'b1; RLAST_S[1] = 1'b1; RREADY_M = 3'b010;
    settle;
    chk("dual_rrel_mr1", 32'(MRIdx[1]), 2);
    tick;
    RVALID_S[1] = 1'b0; RLAST_S[1] = 1'b0;
    settle;
    chk("dual_rfree_mr1", 32'(MRIdx[1]), 0);
    chk("dual_rfree_sr1", 32'(SRIdx[1]), 0);

    // M0 busy on S1 read blocks its request to S4 until the S1 last beat.
    R_REQ[1] = 3'b001;
    settle;
    chk("blk_grant_sr1", 32'(SRIdx[1]), 1);
    tick;
    R_REQ[1] = '0; R_REQ[4] = 3'b001; ARREADY_S[4] = 1'b1; RREADY_M = 3'b001;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("blk_wait_sr4", 32'(SRIdx[4]), 0);
      chk("blk_wait_mr0", 32'(MRIdx[0]), 2);
      tick;
    end
    RVALID_S[1] = 1'b1; RLAST_S[1] = 1'b1;
    settle;
    chk("blk_rel_sr4", 32'(SRIdx[4]), 0);
    tick;
    RVALID_S[1] = 1'b0; RLAST_S[1] = 1'b0;
    settle;
    chk("blk_grant_sr4", 32'(SRIdx[4]), 1);
    chk("blk_grant_mr0", 32'(MRIdx[0]), 5);
    chk("blk_free_sr1", 32'(SRIdx[1]), 0);
    tick;
    R_REQ[4] = '0;

    // RLAST present but master not ready for 5 cycles: grant held.
    RVALID_S[4] = 1'b1; RLAST_S[4] = 1'b1; RREADY_M = '0;
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("stall_sr4", 32'(SRIdx[4]), 1);
      chk("stall_mr0", 32'(MRIdx[0]), 5);
      tick;
    end
    RREADY_M = 3'b001;
    settle;
    chk("stall_rel_sr4", 32'(SRIdx[4]), 1);
    tick;
    RVALID_S[4] = 1'b0; RLAST_S[4] = 1'b0;
    settle;
    chk("stall_free_sr4", 32'(SRIdx[4]), 0);
    chk("stall_free_mr0", 32'(MRIdx[0]), 0);

    // Write on S2 with no B response.
    W_REQ[2] = 3'b001; AWREADY_S[2] = 1'b1;
    settle;
    chk("wdt_grant_sw2", 32'(SWIdx[2]), 1);
    tick;
    W_REQ[2] = '0;
`ifdef ARB_WDT_EN
    for (int i = 0; i < 8; i++) begin
      settle;
      chk("wdt_busy_sw2", 32'(SWIdx[2]), 1);
      chk("wdt_busy_tow", 32'(TO_W), 0);
      tick;
    end
    settle;
    chk("wdt_fire_sw2", 32'(SWIdx[2]), 0);
    chk("wdt_fire_tow", 32'(TO_W), 32'h04);
    tick;
    settle;
    chk("wdt_pulse_end_tow", 32'(TO_W), 0);
`else
    for (int i = 0; i < 12; i++) begin
      settle;
      chk("hold_busy_sw2", 32'(SWIdx[2]), 1);
      chk("hold_busy_tow", 32'(TO_W), 0);
      tick;
    end
    BVALID_S[2] = 1'b1; BREADY_M = 3'b001;
    tick;
    BVALID_S[2] = 1'b0;
    settle;
    chk("hold_free_sw2", 32'(SWIdx[2]), 0);
`endif
    tick;

    // Reset in the middle of a burst.
    R_REQ[5] = 3'b100; ARREADY_S[5] = 1'b1;
    settle;
    chk("mrst_grant_sr5", 32'(SRIdx[5]), 3);
    tick;
    R_REQ[5] = '0;
    settle;
    chk("mrst_busy_sr5", 32'(SRIdx[5]), 3);
    chk("mrst_busy_mr2", 32'(MRIdx[2]), 6);
    rst = 1'b0;
    #1;
    chk("mrst_sr5", 32'(SRIdx[5]), 0);
    chk("mrst_mr2", 32'(MRIdx[2]), 0);
    tick;
    rst = 1'b1;
    tick;
    settle;
    chk_all_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
